// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver/transmitter state encodings and bit-period derivation.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;

    // Truncating division; the caller must keep the result at 4 or more so the
    // half-bit compare value stays positive.
    function automatic int clks_per_bit(input int clk_rate, input int baud_rate);
        return clk_rate / baud_rate;
    endfunction

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs; reset value is a parameter.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic r_meta;
            logic r_sync;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_meta <= RST_VAL[gi];
                    r_sync <= RST_VAL[gi];
                end else begin
                    r_meta <= i_async[gi];
                    r_sync <= r_meta;
                end
            end

            assign o_sync[gi] = r_sync;
        end
    endgenerate

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 (or 8E1 when UART_RX_PARITY_EN is defined), LSB first, idle-high line.
// Each good byte is presented with a one-cycle valid pulse; framing/parity errors pulse frame_err.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_RATE  = 24576000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic [7:0] rx_byte,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_RATE, BAUD_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic        w_rx_s;

    uart_state_t r_state,     w_state_next;
    logic [CNT_W-1:0] r_clk_cnt, w_clk_cnt_next;
    logic [2:0]  r_bit_idx,   w_bit_idx_next;
    logic [7:0]  r_shreg,     w_shreg_next;
    logic [7:0]  r_rx_byte,   w_rx_byte_next;
    logic        r_valid,     w_valid_next;
    logic        r_frame_err, w_frame_err_next;
    logic        w_par_err;
    logic        w_bit_end;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (rx_pin),
        .o_sync  (w_rx_s)
    );

    // After the half-bit start alignment every later full-period count lands mid-bit.
    assign w_bit_end = (r_clk_cnt == CNT_FULL);

`ifdef UART_RX_PARITY_EN
    logic r_par_err, w_par_err_next;
    assign w_par_err = r_par_err;
`else
    assign w_par_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shreg     <= '0;
            r_rx_byte   <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_clk_cnt   <= w_clk_cnt_next;
            r_bit_idx   <= w_bit_idx_next;
            r_shreg     <= w_shreg_next;
            r_rx_byte   <= w_rx_byte_next;
            r_valid     <= w_valid_next;
            r_frame_err <= w_frame_err_next;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_err <= 1'b0;
        end else begin
            r_par_err <= w_par_err_next;
        end
    end
`endif

    always_comb begin
        w_state_next     = r_state;
        w_clk_cnt_next   = r_clk_cnt + 1'b1;
        w_bit_idx_next   = r_bit_idx;
        w_shreg_next     = r_shreg;
        w_rx_byte_next   = r_rx_byte;
        w_valid_next     = 1'b0;
        w_frame_err_next = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_err_next   = r_par_err;
`endif

        case (r_state)
            ST_IDLE: begin
                w_clk_cnt_next = '0;
`ifdef UART_RX_PARITY_EN
                w_par_err_next = 1'b0;
`endif
                if (!w_rx_s) begin
                    w_state_next = ST_START;
                end
            end

            ST_START: begin
                if (r_clk_cnt == CNT_HALF) begin
                    w_clk_cnt_next = '0;
                    w_bit_idx_next = '0;
                    // A start bit that is high again at its centre was only a glitch.
                    w_state_next   = w_rx_s ? ST_IDLE : ST_DATA;
                end
            end

            ST_DATA: begin
                if (w_bit_end) begin
                    w_clk_cnt_next          = '0;
                    w_shreg_next[r_bit_idx] = w_rx_s;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end else begin
                        w_bit_idx_next = r_bit_idx + 3'd1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    w_par_err_next = (w_rx_s != even_parity(r_shreg));
                    w_state_next   = ST_STOP;
                end
            end
`endif

            ST_STOP: begin
                if (w_bit_end) begin
                    w_clk_cnt_next = '0;
                    if (w_rx_s && !w_par_err) begin
                        w_rx_byte_next = r_shreg;
                        w_valid_next   = 1'b1;
                        w_state_next   = ST_IDLE;
                    end else begin
                        w_frame_err_next = 1'b1;
                        w_state_next     = ST_BREAK;
                    end
                end
            end

            ST_BREAK: begin
                // A held-low line must not produce repeated errors; wait for idle.
                w_clk_cnt_next = '0;
                if (w_rx_s) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_clk_cnt_next = '0;
                w_state_next   = ST_IDLE;
            end
        endcase
    end

    assign rx_byte   = r_rx_byte;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: serialises frames onto rx_pin and checks pulses, bytes and timing.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CLK_RATE  = 24576000;
    localparam int BAUD_RATE = 115200;
    localparam int CPB       = CLK_RATE / BAUD_RATE;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_pin = 1'b1;
    logic [7:0] rx_byte;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] vq[$];
    int         vt[$];
    int         n_ferr = 0;
    int         cyc = 0;
    bit         both_hi = 0;
    bit         long_hi = 0;
    logic       prev_v = 1'b0;
    logic       prev_f = 1'b0;

    uart_rx #(
        .CLK_RATE  (CLK_RATE),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_pin    (rx_pin),
        .rx_byte   (rx_byte),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid) begin
            vq.push_back(rx_byte);
            vt.push_back(cyc);
        end
        if (frame_err) n_ferr++;
        if (valid && frame_err) both_hi = 1;
        if ((valid && prev_v) || (frame_err && prev_f)) long_hi = 1;
        prev_v = valid;
        prev_f = frame_err;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_byte"}, {24'd0, rx_byte}, 32'h00);
        check({tag, "_valid"}, {31'd0, valid}, 32'd0);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    // rst_bit >= 0 pulses rst for 3 clocks in the middle of that data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop_v,
                              input logic par_flip, input int rst_bit);
        rx_pin = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_pin = d[i];
            if (i == rst_bit) begin
                tick(CPB / 2);
                rst = 1'b1;
                tick(3);
                check_reset_outputs("mid_frame_rst");
                rst = 1'b0;
                tick(CPB - CPB / 2 - 3);
            end else begin
                tick(CPB);
            end
        end
`ifdef UART_RX_PARITY_EN
        rx_pin = (^d) ^ par_flip;
        tick(CPB);
`else
        if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
        rx_pin = stop_v;
        tick(CPB);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        rx_pin = 1'b1;
        tick(5);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick(10);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // 1: single byte 0x40
        send_frame(8'h40, 1'b1, 1'b0, -1);
        tick(CPB);
        check("t1_count", vq.size(), 32'd1);
        check("t1_byte", {24'd0, vq[0]}, 32'h40);
        check("t1_rx_byte", {24'd0, rx_byte}, 32'h40);
        check("t1_ferr", n_ferr, 32'd0);
        check("t1_busy", {31'd0, busy}, 32'd0);
        $display("txn 1: sent 40, received %02h", rx_byte);

        // 2: back-to-back 0x55, 0xAA
        send_frame(8'h55, 1'b1, 1'b0, -1);
        send_frame(8'hAA, 1'b1, 1'b0, -1);
        tick(CPB);
        check("t2_count", vq.size(), 32'd3);
        check("t2_first", {24'd0, vq[1]}, 32'h55);
        check("t2_second", {24'd0, vq[2]}, 32'hAA);
        check("t2_spacing", vt[2] - vt[1], FRAME_BITS * CPB);
        check("t2_ferr", n_ferr, 32'd0);
        $display("txn 2: sent 55 AA, received %02h %02h spacing %0d", vq[1], vq[2], vt[2] - vt[1]);

        // 3: 50-clock low glitch
        rx_pin = 1'b0;
        tick(10);
        check("t3_busy_during", {31'd0, busy}, 32'd1);
        tick(40);
        rx_pin = 1'b1;
        tick(2 * CPB);
        check("t3_busy_after", {31'd0, busy}, 32'd0);
        check("t3_count", vq.size(), 32'd3);
        check("t3_ferr", n_ferr, 32'd0);
        $display("txn 3: glitch rejected, busy=%0b", busy);

        // 4: bad stop bit with 3 bit-times of low line, then 0x01
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        rx_pin = 1'b0;
        tick(3 * CPB);
        check("t4_busy_break", {31'd0, busy}, 32'd1);
        rx_pin = 1'b1;
        tick(CPB);
        check("t4_ferr", n_ferr, 32'd1);
        check("t4_count", vq.size(), 32'd3);
        check("t4_rx_byte_kept", {24'd0, rx_byte}, 32'hAA);
        check("t4_busy_after", {31'd0, busy}, 32'd0);
        send_frame(8'h01, 1'b1, 1'b0, -1);
        tick(CPB);
        check("t4_next_count", vq.size(), 32'd4);
        check("t4_next_byte", {24'd0, rx_byte}, 32'h01);
        $display("txn 4: framing error count %0d, then received %02h", n_ferr, rx_byte);

        // 5: reset during bit 4 of 0xF0, then 0x0F
        send_frame(8'hF0, 1'b1, 1'b0, 4);
        tick(CPB);
        check("t5_count", vq.size(), 32'd4);
        check("t5_ferr", n_ferr, 32'd1);
        check("t5_rx_byte", {24'd0, rx_byte}, 32'h00);
        send_frame(8'h0F, 1'b1, 1'b0, -1);
        tick(CPB);
        check("t5_next_count", vq.size(), 32'd5);
        check("t5_next_byte", {24'd0, rx_byte}, 32'h0F);
        $display("txn 5: reset mid-frame, then received %02h", rx_byte);

`ifdef UART_RX_PARITY_EN
        // 6: parity error then good parity
        send_frame(8'h07, 1'b1, 1'b1, -1);
        tick(CPB);
        check("t6_ferr", n_ferr, 32'd2);
        check("t6_count", vq.size(), 32'd5);
        check("t6_rx_byte_kept", {24'd0, rx_byte}, 32'h0F);
        send_frame(8'h07, 1'b1, 1'b0, -1);
        tick(CPB);
        check("t6_next_count", vq.size(), 32'd6);
        check("t6_next_byte", {24'd0, rx_byte}, 32'h07);
        $display("txn 6: parity error count %0d, then received %02h", n_ferr, rx_byte);
`endif

        check("no_overlap", {31'd0, both_hi}, 32'd0);
        check("single_cycle", {31'd0, long_hi}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
